// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: Wishbone master bus carried between dds_sweep_ctrl and the simple_dds slave.
// Ports / signals:
//   m_wb_addr_o  master address        m_wb_dat_o  master write data
//   m_wb_we_o    write enable          m_wb_stb_o  strobe (cycle valid)
//   m_wb_dat_i   slave read data       m_wb_ack_i  slave acknowledge
// Modports: master (sweep controller side), slave (DDS register bank side).
interface dds_sweep_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_wb_addr_o;
    logic [DATA_WIDTH-1:0] m_wb_dat_o;
    logic                  m_wb_we_o;
    logic                  m_wb_stb_o;
    logic [DATA_WIDTH-1:0] m_wb_dat_i;
    logic                  m_wb_ack_i;

    modport master (
        output m_wb_addr_o, m_wb_dat_o, m_wb_we_o, m_wb_stb_o,
        input  m_wb_dat_i, m_wb_ack_i
    );

    modport slave (
        input  m_wb_addr_o, m_wb_dat_o, m_wb_we_o, m_wb_stb_o,
        output m_wb_dat_i, m_wb_ack_i
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: Wishbone master that programs the simple_dds register bank and steps
// TUNING_WORD from tw_start to tw_stop with a programmable dwell per step.
// Ports:
//   wb_clk_i, wb_rst_n_i       clock / asynchronous active-low reset
//   start_i, abort_i           1-cycle start / abort pulses
//   src_i, gain_i, offset_i    DDS_SRC / GAIN_WORD / OFFSET_WORD values (captured on start)
//   tw_start_i/stop_i/step_i   sweep tuning words (captured on start)
//   dwell_i                    cycles per step (0 behaves as 1)
//   loop_i                     only with DDS_SWEEP_LOOP_EN: restart from tw_start at stop-dwell end
//   m_wb                       Wishbone master bus (dds_sweep_ctrl_if.master)
//   busy_o, done_o, err_o      status: active, end-of-sweep pulse, sticky error
//   cur_tw_o                   tuning word last acknowledged by the DDS
// Optional feature macro: DDS_SWEEP_LOOP_EN (continuous looping sweep).
module dds_sweep_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DWELL_WIDTH = 16,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned POLL_LIMIT  = 64
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
`ifdef DDS_SWEEP_LOOP_EN
    input  logic                   loop_i,
`endif
    input  logic [1:0]             src_i,
    input  logic [1:0]             gain_i,
    input  logic [15:0]            offset_i,
    input  logic [7:0]             tw_start_i,
    input  logic [7:0]             tw_stop_i,
    input  logic [7:0]             tw_step_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    dds_sweep_ctrl_if.master       m_wb,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [7:0]             cur_tw_o
);
    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned PC_W = $clog2(POLL_LIMIT + 1);

    localparam logic [ADDR_WIDTH-1:0] A_READY  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_ENABLE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_SRC    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_TW     = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_GAIN   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_OFFSET = ADDR_WIDTH'(5);

    typedef enum logic [3:0] {
        IDLE, POLL, SRC, GAIN, OFF, TW, EN, DWELL, STEP, DIS, FIN
    } state_e;

    typedef struct packed {
        logic [1:0]             src;
        logic [1:0]             gain;
        logic [15:0]            offset;
        logic [7:0]             tw_start;
        logic [7:0]             tw_stop;
        logic [7:0]             tw_step;
        logic [DWELL_WIDTH-1:0] dwell;
        logic                   up;
    } cfg_t;

    state_e                  state_q, state_d;
    cfg_t                    cfg_q, cfg_d;
    logic                    stb_q, stb_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [PC_W-1:0]         poll_cnt_q, poll_cnt_d;
    logic [DWELL_WIDTH-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [7:0]              tw_q, tw_d, cur_tw_q, cur_tw_d;
    logic                    en_done_q, en_done_d, abort_q, abort_d;
    logic                    err_q, err_d, busy_q, busy_d, done_q, done_d;

    logic                    is_bus, bus_done, abort_pend;
    state_e                  abort_tgt;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_dat;
    logic [8:0]              sum9, dif9;
    logic [7:0]              next_tw;
    logic                    unused_dat;

    assign unused_dat = ^m_wb.m_wb_dat_i[DATA_WIDTH-1:1];

    // State and output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dat_q       <= '0;
            to_cnt_q    <= '0;
            poll_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            tw_q        <= '0;
            cur_tw_q    <= '0;
            en_done_q   <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            to_cnt_q    <= to_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            tw_q        <= tw_d;
            cur_tw_q    <= cur_tw_d;
            en_done_q   <= en_done_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next tuning word, clamped to stop when it reaches, passes or wraps past it
    always_comb begin
        sum9 = {1'b0, tw_q} + {1'b0, cfg_q.tw_step};
        dif9 = {1'b0, tw_q} - {1'b0, cfg_q.tw_step};
        if (cfg_q.up) begin
            next_tw = (sum9[8] || (sum9[7:0] >= cfg_q.tw_stop)) ? cfg_q.tw_stop : sum9[7:0];
        end else begin
            next_tw = (dif9[8] || (dif9[7:0] <= cfg_q.tw_stop)) ? cfg_q.tw_stop : dif9[7:0];
        end
    end

    // Sequencer: bus-cycle engine shared by all register-access states, then per-state flow
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        to_cnt_d    = '0;
        poll_cnt_d  = poll_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        tw_d        = tw_q;
        cur_tw_d    = cur_tw_q;
        en_done_d   = en_done_q;
        err_d       = err_q;
        bus_done    = 1'b0;
        req_we      = 1'b1;
        req_addr    = A_READY;
        req_dat     = '0;

        // Abort is remembered until the sweep reaches FIN; it is meaningless in IDLE
        abort_pend = abort_q | abort_i;
        abort_tgt  = en_done_q ? DIS : FIN;
        abort_d    = (state_q == IDLE || state_q == FIN) ? 1'b0 : abort_pend;

        case (state_q)
            POLL:    req_we = 1'b0;
            SRC:     begin req_addr = A_SRC;    req_dat = DATA_WIDTH'(cfg_q.src);    end
            GAIN:    begin req_addr = A_GAIN;   req_dat = DATA_WIDTH'(cfg_q.gain);   end
            OFF:     begin req_addr = A_OFFSET; req_dat = DATA_WIDTH'(cfg_q.offset); end
            TW:      begin req_addr = A_TW;     req_dat = DATA_WIDTH'(tw_q);         end
            EN:      begin req_addr = A_ENABLE; req_dat = DATA_WIDTH'(1);            end
            DIS:     begin req_addr = A_ENABLE; req_dat = '0;                        end
            default: ;
        endcase

        is_bus = state_q inside {POLL, SRC, GAIN, OFF, TW, EN, DIS};
        if (is_bus) begin
            if (!stb_q) begin
                // Idle slot between transactions: either divert on abort or launch the cycle
                if (abort_pend && state_q != DIS) begin
                    state_d = abort_tgt;
                end else begin
                    stb_d  = 1'b1;
                    we_d   = req_we;
                    addr_d = req_addr;
                    dat_d  = req_dat;
                end
            end else if (m_wb.m_wb_ack_i) begin
                stb_d    = 1'b0;
                we_d     = 1'b0;
                addr_d   = '0;
                dat_d    = '0;
                bus_done = 1'b1;
            end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                // Slave never answered: give up without touching ENABLE
                stb_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = '0;
                dat_d   = '0;
                err_d   = 1'b1;
                state_d = FIN;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    cfg_d.src      = src_i;
                    cfg_d.gain     = gain_i;
                    cfg_d.offset   = offset_i;
                    cfg_d.tw_start = tw_start_i;
                    cfg_d.tw_stop  = tw_stop_i;
                    cfg_d.tw_step  = (tw_step_i == 8'd0) ? 8'd1 : tw_step_i;
                    cfg_d.dwell    = (dwell_i == '0) ? DWELL_WIDTH'(1) : dwell_i;
                    cfg_d.up       = (tw_stop_i >= tw_start_i);
                    tw_d           = tw_start_i;
                    err_d          = 1'b0;
                    poll_cnt_d     = '0;
                    en_done_d      = 1'b0;
                    state_d        = POLL;
                end
            end
            POLL: begin
                if (bus_done) begin
                    if (abort_pend) begin
                        state_d = abort_tgt;
                    end else if (m_wb.m_wb_dat_i[0]) begin
                        state_d = SRC;
                    end else if (poll_cnt_q == PC_W'(POLL_LIMIT - 1)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PC_W'(1);
                    end
                end
            end
            SRC:  if (bus_done) state_d = abort_pend ? abort_tgt : GAIN;
            GAIN: if (bus_done) state_d = abort_pend ? abort_tgt : OFF;
            OFF:  if (bus_done) state_d = abort_pend ? abort_tgt : TW;
            TW: begin
                if (bus_done) begin
                    cur_tw_d    = tw_q;
                    dwell_cnt_d = '0;
                    if (abort_pend)     state_d = abort_tgt;
                    else if (en_done_q) state_d = DWELL;
                    else                state_d = EN;
                end
            end
            EN: begin
                if (bus_done) begin
                    en_done_d   = 1'b1;
                    dwell_cnt_d = '0;
                    state_d     = abort_pend ? DIS : DWELL;
                end
            end
            DWELL: begin
                if (abort_pend) begin
                    state_d = abort_tgt;
                end else if (dwell_cnt_q == cfg_q.dwell - DWELL_WIDTH'(1)) begin
                    if (tw_q == cfg_q.tw_stop) begin
`ifdef DDS_SWEEP_LOOP_EN
                        if (loop_i) begin
                            tw_d    = cfg_q.tw_start;
                            state_d = TW;
                        end else begin
                            state_d = DIS;
                        end
`else
                        state_d = DIS;
`endif
                    end else begin
                        state_d = STEP;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_WIDTH'(1);
                end
            end
            STEP: begin
                if (abort_pend) begin
                    state_d = abort_tgt;
                end else begin
                    tw_d    = next_tw;
                    state_d = TW;
                end
            end
            DIS:     if (bus_done) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    assign m_wb.m_wb_addr_o = addr_q;
    assign m_wb.m_wb_dat_o  = dat_q;
    assign m_wb.m_wb_we_o   = we_q;
    assign m_wb.m_wb_stb_o  = stb_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign cur_tw_o         = cur_tw_q;
endmodule
